// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges ALU results and buffered long-latency results onto the register-file write port.
// Optional starvation guard compiled in with `define WRITEBACK_STARVE_GUARD_EN.
module writeback_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_stall,
    input  logic        ext_valid,
    output logic        ext_ready,
    input  logic [4:0]  ext_rd,
    input  logic [31:0] ext_data,
    output logic        ext_pending,
    output logic [4:0]  write_address,
    output logic [31:0] write_data,
    output logic        write_enable
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [4:0]      waddr_q, waddr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            wen_q, wen_d;

    logic   empty, full, push, pop, take_alu;
    entry_t head, sel;

    assign empty       = (count_q == '0);
    assign full        = (count_q == CW'(DEPTH));
    assign ext_ready   = !full && !reset;
    assign push        = ext_valid && ext_ready;
    assign ext_pending = !empty;
    assign head        = mem_q[rd_ptr_q];

    assign write_address = waddr_q;
    assign write_data    = wdata_q;
    assign write_enable  = wen_q;

    // A stalled ALU yields to the buffer; otherwise the ALU has priority.
    always_comb begin
        pop      = 1'b0;
        take_alu = 1'b0;
        if (alu_stall && !empty) begin
            pop = 1'b1;
        end else if (alu_valid && !alu_stall) begin
            take_alu = 1'b1;
        end else if (!empty) begin
            pop = 1'b1;
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = {ext_rd, ext_data};
        end
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // rd=0 entries are consumed without touching the held address/data.
    always_comb begin
        sel     = take_alu ? {alu_rd, alu_data} : head;
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if ((pop || take_alu) && sel.rd != 5'd0) begin
            wen_d   = 1'b1;
            waddr_d = sel.rd;
            wdata_d = sel.data;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            wen_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            wen_q    <= wen_d;
        end
    end

`ifdef WRITEBACK_STARVE_GUARD_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_q, starve_d;
    logic       stall_q, stall_d;

    assign alu_stall = stall_q;

    always_comb begin
        starve_d = starve_q;
        if (empty || pop) begin
            starve_d = '0;
        end else if (starve_q != 4'hF) begin
            starve_d = starve_q + 4'd1;
        end
        stall_d = (stall_q && !empty) || (starve_q == LIMIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end
`else
    logic unused_limit;
    assign unused_limit = ^4'(STARVE_LIMIT);
    assign alu_stall    = 1'b0;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed vector bench for writeback_arbiter (DEPTH=2, STARVE_LIMIT=4).
// Starvation sequence follows whether WRITEBACK_STARVE_GUARD_EN is defined.
module tb_writeback_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_stall;
    logic        ext_valid;
    logic        ext_ready;
    logic [4:0]  ext_rd;
    logic [31:0] ext_data;
    logic        ext_pending;
    logic [4:0]  write_address;
    logic [31:0] write_data;
    logic        write_enable;

    always #5 clk = ~clk;

    writeback_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk(clk),
        .reset(reset),
        .alu_valid(alu_valid),
        .alu_rd(alu_rd),
        .alu_data(alu_data),
        .alu_stall(alu_stall),
        .ext_valid(ext_valid),
        .ext_ready(ext_ready),
        .ext_rd(ext_rd),
        .ext_data(ext_data),
        .ext_pending(ext_pending),
        .write_address(write_address),
        .write_data(write_data),
        .write_enable(write_enable)
    );

    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        ev;
        logic [4:0]  erd;
        logic [31:0] ed;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        rdy;
        logic        pend;
        logic        stall;
    } vec_t;

    vec_t tbl[16];
    int   applied     = 0;
    int   miscompares = 0;

    task automatic set(input int i, input logic r, input logic av,
                       input logic [4:0] ard, input logic [31:0] ad,
                       input logic ev, input logic [4:0] erd,
                       input logic [31:0] ed, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd,
                       input logic rdy, input logic pend, input logic st);
        tbl[i] = '{r, av, ard, ad, ev, erd, ed, we, wa, wd, rdy, pend, st};
    endtask

    task automatic drive(input logic r, input logic av,
                         input logic [4:0] ard, input logic [31:0] ad,
                         input logic ev, input logic [4:0] erd,
                         input logic [31:0] ed);
        reset     = r;
        alu_valid = av;
        alu_rd    = ard;
        alu_data  = ad;
        ext_valid = ev;
        ext_rd    = erd;
        ext_data  = ed;
    endtask

    task automatic check(input string name, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd,
                         input logic rdy, input logic pend, input logic st);
        applied++;
        if ({write_enable, write_address, write_data, ext_ready,
             ext_pending, alu_stall} !== {we, wa, wd, rdy, pend, st}) begin
            miscompares++;
            $display("FAIL %s: got we=%b addr=%0d data=%0d rdy=%b pend=%b stall=%b, want we=%b addr=%0d data=%0d rdy=%b pend=%b stall=%b",
                     name, write_enable, write_address, write_data,
                     ext_ready, ext_pending, alu_stall,
                     we, wa, wd, rdy, pend, st);
        end
    endtask

    initial begin
        // Expected outputs are those seen in the cycle the inputs are applied.
        set(0,  1, 1, 5, 1,    1, 3, 7,     0, 0, 0,    0, 0, 0);
        set(1,  1, 1, 5, 1,    1, 3, 7,     0, 0, 0,    0, 0, 0);
        set(2,  1, 1, 5, 1,    1, 3, 7,     0, 0, 0,    0, 0, 0);
        set(3,  0, 0, 0, 0,    0, 0, 0,     0, 0, 0,    1, 0, 0);
        set(4,  0, 1, 5, 1234, 0, 0, 0,     0, 0, 0,    1, 0, 0);
        set(5,  0, 1, 0, 99,   0, 0, 0,     1, 5, 1234, 1, 0, 0);
        set(6,  0, 0, 0, 0,    1, 2, 5678,  0, 5, 1234, 1, 0, 0);
        set(7,  0, 0, 0, 0,    0, 0, 0,     0, 5, 1234, 1, 1, 0);
        set(8,  0, 1, 9, 900,  1, 11, 111,  1, 2, 5678, 1, 0, 0);
        set(9,  0, 1, 10, 1000, 1, 12, 222, 1, 9, 900,  1, 1, 0);
        set(10, 0, 1, 13, 1300, 1, 14, 333, 1, 10, 1000, 0, 1, 0);
        set(11, 0, 0, 0, 0,    1, 14, 333,  1, 13, 1300, 0, 1, 0);
        set(12, 0, 0, 0, 0,    1, 14, 333,  1, 11, 111, 1, 1, 0);
        set(13, 0, 0, 0, 0,    0, 0, 0,     1, 12, 222, 1, 1, 0);
        set(14, 0, 0, 0, 0,    0, 0, 0,     1, 14, 333, 1, 0, 0);
        set(15, 0, 0, 0, 0,    0, 0, 0,     0, 14, 333, 1, 0, 0);

        drive(1, 1, 5, 1, 1, 3, 7);
        @(posedge clk);

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].av, tbl[i].ard, tbl[i].ad,
                  tbl[i].ev, tbl[i].erd, tbl[i].ed);
            #1;
            check($sformatf("vec%0d", i), tbl[i].we, tbl[i].wa, tbl[i].wd,
                  tbl[i].rdy, tbl[i].pend, tbl[i].stall);
        end

        // Reset while two entries are buffered flushes them.
        @(negedge clk); drive(0, 1, 9, 500, 1, 20, 1);
        @(negedge clk); drive(0, 1, 9, 500, 1, 21, 2);
        @(negedge clk); drive(1, 1, 9, 500, 1, 22, 3);
        #1; check("rst_mid", 1, 9, 500, 0, 1, 0);
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0);
        #1; check("rst_flush", 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        #1; check("rst_idle", 0, 0, 0, 1, 0, 0);

        // One buffered entry behind a continuously valid ALU.
        @(negedge clk); drive(0, 1, 9, 500, 1, 7, 42);
        @(negedge clk); drive(0, 1, 9, 500, 0, 0, 0);
        #1; check("starve_c1", 1, 9, 500, 1, 1, 0);
`ifdef WRITEBACK_STARVE_GUARD_EN
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            #1; check($sformatf("starve_c%0d", k), 1, 9, 500, 1, 1, 0);
        end
        @(negedge clk);
        #1; check("starve_stall", 1, 9, 500, 1, 1, 1);
        @(negedge clk);
        #1; check("starve_drain", 1, 7, 42, 1, 0, 1);
        @(negedge clk);
        #1; check("starve_clear", 0, 7, 42, 1, 0, 0);
        @(negedge clk);
        #1; check("starve_alu", 1, 9, 500, 1, 0, 0);
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0);
        #1; check("starve_tail", 1, 9, 500, 1, 0, 0);
        @(negedge clk);
        #1; check("starve_idle", 0, 9, 500, 1, 0, 0);
`else
        for (int k = 2; k <= 8; k++) begin
            @(negedge clk);
            #1; check($sformatf("noguard_c%0d", k), 1, 9, 500, 1, 1, 0);
        end
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0);
        #1; check("noguard_release", 1, 9, 500, 1, 1, 0);
        @(negedge clk);
        #1; check("noguard_drain", 1, 7, 42, 1, 0, 0);
        @(negedge clk);
        #1; check("noguard_idle", 0, 7, 42, 1, 0, 0);
`endif

        // Six pushes with gaps, idle ALU: pointers wrap, order kept.
        begin
            logic [36:0] expq[$];
            logic [36:0] got;
            logic [36:0] want;
            logic        pat[16];
            int          pushed = 0;
            int          seen   = 0;
            logic [4:0]  rd;
            logic [31:0] dat;
            pat = '{1, 1, 0, 1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                if (pat[c] && pushed < 6) begin
                    rd  = 5'(pushed + 1);
                    dat = 32'hA000 + 32'(pushed * 17);
                    drive(0, 0, 0, 0, 1, rd, dat);
                    expq.push_back({rd, dat});
                    pushed++;
                end else begin
                    drive(0, 0, 0, 0, 0, 0, 0);
                end
                #1;
                if (write_enable === 1'b1) begin
                    applied++;
                    got  = {write_address, write_data};
                    want = (expq.size() > 0) ? expq.pop_front() : 37'h0;
                    if (got !== want) begin
                        miscompares++;
                        $display("FAIL wrap_order: got rd=%0d data=%h, want rd=%0d data=%h",
                                 got[36:32], got[31:0], want[36:32], want[31:0]);
                    end
                    seen++;
                end
            end
            applied++;
            if (seen != 6 || expq.size() != 0) begin
                miscompares++;
                $display("FAIL wrap_count: got %0d writes, want 6", seen);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
